prim_rec_node: RTL and testbench

//  Parametrised primitive-recursion node: f(x,0)=g(x); f(x,n+1)=h(x,n,f(x,n)).

---
 rtl/prim_rec_node.sv | 116 +++++++++++
 tb/tb_prim_rec_node.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_rec_node.sv
// Primitive-recursion R-operator node: computes f(x,N) by starting child g once
// and then child h N times, counting n and threading the accumulator.
module prim_rec_node #(
  parameter int W     = 16,
  parameter int NARGS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ST,
  input  logic [NARGS*W-1:0]   X,
  input  logic [W-1:0]         N,
  output logic                 RD,
  output logic [W-1:0]         RES,
  output logic [NARGS*W-1:0]   XQ,
  output logic                 G_ST,
  input  logic                 G_RD,
  input  logic [W-1:0]         G_RES,
  output logic                 H_ST,
  output logic [W-1:0]         H_CNT,
  output logic [W-1:0]         H_ACC,
  input  logic                 H_RD,
  input  logic [W-1:0]         H_RES
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GWAIT = 2'd1,
    S_HWAIT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       r_state;
  logic [W-1:0] r_nq;
  logic         r_st_q;
  logic         r_g_rd_q;
  logic         r_h_rd_q;

  logic         w_st_edge;
  logic         w_g_acc;
  logic         w_h_acc;
  logic [W-1:0] w_cnt_nxt;

  assign w_st_edge = ST & ~r_st_q;
  assign w_g_acc   = G_RD & ~r_g_rd_q;
  assign w_h_acc   = H_RD & ~r_h_rd_q;
  assign w_cnt_nxt = H_CNT + ONE;

  // Edge-detect history is sampled every cycle, independent of state and reset,
  // so a level already high when a run starts never counts as a new edge.
  always_ff @(posedge CLK) begin
    r_st_q   <= ST;
    r_g_rd_q <= G_RD;
    r_h_rd_q <= H_RD;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_nq    <= '0;
      RD      <= 1'b1;
      RES     <= '0;
      XQ      <= '0;
      G_ST    <= 1'b0;
      H_ST    <= 1'b0;
      H_CNT   <= '0;
      H_ACC   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_st_edge) begin
            XQ      <= X;
            r_nq    <= N;
            H_CNT   <= '0;
            RD      <= 1'b0;
            G_ST    <= 1'b1;
            r_state <= S_GWAIT;
          end
        end
        S_GWAIT: begin
          G_ST <= 1'b0;
          if (w_g_acc) begin
            H_ACC <= G_RES;
            if (r_nq == '0) begin
              r_state <= S_DONE;
            end else begin
              H_ST    <= 1'b1;
              r_state <= S_HWAIT;
            end
          end
        end
        S_HWAIT: begin
          H_ST <= 1'b0;
          if (w_h_acc) begin
            H_ACC <= H_RES;
            H_CNT <= w_cnt_nxt;
            // NQ <= 2^W-1, so the count stops before it could wrap
            if (w_cnt_nxt == r_nq) begin
              r_state <= S_DONE;
            end else begin
              H_ST <= 1'b1;
            end
          end
        end
        S_DONE: begin
          RES     <= H_ACC;
          RD      <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_rec_node.sv
// Bench for prim_rec_node: behavioural child stubs, a reference f(x,n) model
// checked every cycle, plus directed runs with hand-computed results.
module tb_prim_rec_node;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ST;
  logic [31:0] X;
  logic [15:0] N;
  logic        RD;
  logic [15:0] RES;
  logic [31:0] XQ;
  logic        G_ST, H_ST;
  logic [15:0] H_CNT, H_ACC;
  logic        g_rd, h_rd;
  logic [15:0] g_res, h_res;

  logic        ST8;
  logic [15:0] X8;
  logic [7:0]  N8;
  logic        RD8, G_ST8, H_ST8;
  logic [7:0]  RES8, H_CNT8, H_ACC8;
  logic [15:0] XQ8;
  logic        g8_rd, h8_rd, g8_busy, h8_busy;
  logic [7:0]  g8_res, h8_res;

  always #5 CLK = ~CLK;

  prim_rec_node #(.W(16), .NARGS(2)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .X(X), .N(N), .RD(RD), .RES(RES), .XQ(XQ),
    .G_ST(G_ST), .G_RD(g_rd), .G_RES(g_res),
    .H_ST(H_ST), .H_CNT(H_CNT), .H_ACC(H_ACC), .H_RD(h_rd), .H_RES(h_res)
  );

  prim_rec_node #(.W(8), .NARGS(2)) dut8 (
    .CLK(CLK), .RST(RST), .ST(ST8), .X(X8), .N(N8), .RD(RD8), .RES(RES8), .XQ(XQ8),
    .G_ST(G_ST8), .G_RD(g8_rd), .G_RES(g8_res),
    .H_ST(H_ST8), .H_CNT(H_CNT8), .H_ACC(H_ACC8), .H_RD(h8_rd), .H_RES(h8_res)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: g(x) = x0, h(x,n,a) = a+1 (mode 0) or a+n+x1 (mode 1)
  function automatic logic [15:0] fref(input logic [15:0] x0, input logic [15:0] x1,
                                       input int n, input bit hm);
    logic [15:0] acc;
    acc = x0;
    for (int i = 0; i < n; i++) acc = hm ? acc + 16'(i) + x1 : acc + 16'd1;
    return acc;
  endfunction

  bit          hmode   = 1'b0;
  bit          rnd_lat = 1'b0;
  bit          chk_en  = 1'b0;
  logic        rst_d;
  logic [15:0] mx0 = '0, mx1 = '0;
  bit          mhm = 1'b0;
  logic [15:0] exp_cur = '0, exp_prev = '0;
  int          g_tot = 0, h_tot = 0, g_base = 0, h_base = 0;
  int          h8n = 0, h8max = 0;
  logic        g_st_d = 1'b0, h_st_d = 1'b0;

  // 16-bit child stubs: ready drops on start, rises with the result after a latency
  logic       g_busy, h_busy;
  logic [4:0] g_cnt, h_cnt_s;
  logic [15:0] g_val, h_val;

  always @(posedge CLK) begin
    rst_d <= RST;
    if (RST) begin
      g_rd <= 1'b1; g_busy <= 1'b0; g_res <= '0; g_cnt <= '0; g_val <= '0;
      h_rd <= 1'b1; h_busy <= 1'b0; h_res <= '0; h_cnt_s <= '0; h_val <= '0;
    end else begin
      if (G_ST) begin
        g_rd <= 1'b0; g_busy <= 1'b1; g_val <= XQ[15:0];
        g_cnt <= rnd_lat ? 5'($urandom_range(1, 20)) : 5'd1;
      end else if (g_busy) begin
        if (g_cnt <= 5'd1) begin
          g_rd <= 1'b1; g_res <= g_val; g_busy <= 1'b0;
        end else g_cnt <= g_cnt - 5'd1;
      end
      if (H_ST) begin
        h_rd <= 1'b0; h_busy <= 1'b1;
        h_val <= hmode ? H_ACC + H_CNT + XQ[31:16] : H_ACC + 16'd1;
        h_cnt_s <= rnd_lat ? 5'($urandom_range(1, 20)) : 5'd1;
      end else if (h_busy) begin
        if (h_cnt_s <= 5'd1) begin
          h_rd <= 1'b1; h_res <= h_val; h_busy <= 1'b0;
        end else h_cnt_s <= h_cnt_s - 5'd1;
      end
    end
  end

  // 8-bit child stubs: g = 0, h = acc+1, latency 1
  always @(posedge CLK) begin
    if (RST) begin
      g8_rd <= 1'b1; g8_busy <= 1'b0; g8_res <= '0;
      h8_rd <= 1'b1; h8_busy <= 1'b0; h8_res <= '0;
    end else begin
      if (G_ST8) begin g8_rd <= 1'b0; g8_busy <= 1'b1; end
      else if (g8_busy) begin g8_rd <= 1'b1; g8_res <= 8'd0; g8_busy <= 1'b0; end
      if (H_ST8) begin h8_rd <= 1'b0; h8_busy <= 1'b1; h8_res <= H_ACC8 + 8'd1; end
      else if (h8_busy) begin h8_rd <= 1'b1; h8_busy <= 1'b0; end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      if (rst_d) begin
        chk("rst_rd", 32'(RD), 32'd1);
        chk("rst_res", 32'(RES), 32'd0);
        chk("rst_gst", 32'(G_ST), 32'd0);
        chk("rst_hst", 32'(H_ST), 32'd0);
        chk("rst_hcnt", 32'(H_CNT), 32'd0);
        chk("rst_hacc", 32'(H_ACC), 32'd0);
        chk("rst_xq", XQ, 32'd0);
      end else begin
        if (RD) chk("res_valid", 32'(RES), 32'(exp_cur));
        else    chk("res_hold", 32'(RES), 32'(exp_prev));
        if (G_ST) begin
          chk("g_xq", XQ, {mx1, mx0});
          chk("g_width", 32'(g_st_d), 32'd0);
          g_tot++;
        end
        if (H_ST) begin
          chk("h_cnt", 32'(H_CNT), 32'(h_tot - h_base));
          chk("h_acc", 32'(H_ACC), 32'(fref(mx0, mx1, h_tot - h_base, mhm)));
          chk("h_width", 32'(h_st_d), 32'd0);
          h_tot++;
        end
      end
      if (H_ST8) begin
        chk("h8_cnt", 32'(H_CNT8), 32'(h8n));
        chk("h8_acc", 32'(H_ACC8), 32'(h8n));
        if (int'(H_CNT8) > h8max) h8max = int'(H_CNT8);
        h8n++;
      end
    end
    g_st_d = G_ST;
    h_st_d = H_ST;
  end

  task automatic launch(input logic [15:0] x1, input logic [15:0] x0,
                        input logic [15:0] n, input bit hold);
    @(posedge CLK); #1;
    X = {x1, x0}; N = n; ST = 1'b1;
    @(posedge CLK);
    exp_prev = exp_cur;
    mx0 = x0; mx1 = x1; mhm = hmode;
    exp_cur = fref(x0, x1, int'(n), hmode);
    g_base = g_tot; h_base = h_tot;
    #1;
    if (!hold) ST = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      if (RD === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL %s: RD still %0b after %0d cycles, expected 1", nm, RD, budget);
    end
  endtask

  initial begin
    bit ok;
    RST = 1'b1; ST = 1'b0; X = '0; N = '0;
    ST8 = 1'b0; X8 = '0; N8 = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("init_rd", 32'(RD), 32'd1);

    // N=0: only g runs, result is x0
    launch(16'd7, 16'd5, 16'd0, 1'b0);
    wait_done("t1_done", 200);
    chk("t1_res", 32'(RES), 32'd5);
    chk("t1_gpulses", 32'(g_tot - g_base), 32'd1);
    chk("t1_hpulses", 32'(h_tot - h_base), 32'd0);

    // N=3: three h iterations, 5+3
    launch(16'd7, 16'd5, 16'd3, 1'b0);
    wait_done("t2_done", 200);
    chk("t2_res", 32'(RES), 32'd8);
    chk("t2_hpulses", 32'(h_tot - h_base), 32'd3);

    // second ST edge plus X/N changes mid-run are ignored
    launch(16'd7, 16'd5, 16'd3, 1'b0);
    repeat (3) @(posedge CLK);
    #1 ST = 1'b1; X = {16'd9, 16'd9}; N = 16'd1;
    @(posedge CLK); #1 ST = 1'b0;
    wait_done("t3_done", 200);
    chk("t3_res", 32'(RES), 32'd8);
    chk("t3_hpulses", 32'(h_tot - h_base), 32'd3);
    chk("t3_gpulses", 32'(g_tot - g_base), 32'd1);

    // reset mid-run (in H_WAIT of N=5), then a fresh N=2 run
    launch(16'd7, 16'd5, 16'd5, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (h_tot - h_base >= 2) ok = 1'b1;
    end
    chk("t4_reached_hwait", 32'(ok), 32'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK);
    exp_prev = '0; exp_cur = '0;
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("t4_rd", 32'(RD), 32'd1);
    chk("t4_res", 32'(RES), 32'd0);
    chk("t4_gst", 32'(G_ST), 32'd0);
    chk("t4_hst", 32'(H_ST), 32'd0);
    launch(16'd7, 16'd5, 16'd2, 1'b0);
    wait_done("t4b_done", 200);
    chk("t4b_res", 32'(RES), 32'd7);

    // random latencies, ST held high, h = acc+n+x1: 100 -> 103,107,112,118
    hmode = 1'b1; rnd_lat = 1'b1;
    launch(16'd3, 16'd100, 16'd4, 1'b1);
    wait_done("t5_done", 400);
    chk("t5_res", 32'(RES), 32'd118);
    chk("t5_model", 32'(exp_cur), 32'd118);
    repeat (40) @(negedge CLK);
    chk("t5_no_restart", 32'(g_tot - g_base), 32'd1);
    chk("t5_rd_held", 32'(RD), 32'd1);
    #1 ST = 1'b0;
    hmode = 1'b0; rnd_lat = 1'b0;

    // W=8, N=255: counter reaches 254 without wrapping, result 255
    @(posedge CLK); #1 N8 = 8'd255; ST8 = 1'b1;
    @(posedge CLK); #1 ST8 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge CLK);
      if (RD8 === 1'b1) ok = 1'b1;
    end
    chk("t6_done", 32'(ok), 32'd1);
    chk("t6_res", 32'(RES8), 32'd255);
    chk("t6_hpulses", 32'(h8n), 32'd255);
    chk("t6_hcnt_max", 32'(h8max), 32'd254);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
